// File: rtl/case_6_prod_accum_if.sv
// case_6_prod_accum_if
// Handshake bundle between the case_6 multiplier, the frame accumulator and
// the stage that consumes frame results.
//   prod_in / prod_vld / prod_rdy : signed product stream into the accumulator
//   acc_out / acc_ovf / acc_vld / acc_rdy : saturated frame result out of it
// Modports:
//   master : the environment (drives products, accepts results)
//   slave  : the accumulator
interface case_6_prod_accum_if #(
  parameter int DIN_WIDTH = 11,
  parameter int ACC_WIDTH = 16
);
  logic signed [DIN_WIDTH-1:0] prod_in;
  logic                        prod_vld;
  logic                        prod_rdy;
  logic signed [ACC_WIDTH-1:0] acc_out;
  logic                        acc_ovf;
  logic                        acc_vld;
  logic                        acc_rdy;

  modport master (
    output prod_in, prod_vld, acc_rdy,
    input  prod_rdy, acc_out, acc_ovf, acc_vld
  );

  modport slave (
    input  prod_in, prod_vld, acc_rdy,
    output prod_rdy, acc_out, acc_ovf, acc_vld
  );
endinterface

// File: rtl/case_6_prod_accum.sv
// case_6_prod_accum
// Saturating signed accumulator behind the 11s x 4s multiplier. Sums each
// frame of LEN products with a clamp at every step, then holds one result
// (plus a sticky per-frame overflow flag) until downstream takes it.
// Ports:
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset
//   bus      : slave side of case_6_prod_accum_if (product in, result out);
//              its DIN_WIDTH/ACC_WIDTH must match this module's parameters
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_ACC  | accumulating a frame; prod_rdy = 1, acc_vld = 0
// ST_HOLD | result pending;       prod_rdy = acc_rdy, acc_vld = 1
module case_6_prod_accum #(
  parameter int DIN_WIDTH = 11,
  parameter int ACC_WIDTH = 16,
  parameter int LEN       = 8
) (
  input logic ap_clk,
  input logic ap_rst_n,
  case_6_prod_accum_if.slave bus
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam int EXT = ACC_WIDTH + 1 - DIN_WIDTH;
  localparam logic [7:0] LAST = 8'(LEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                      state;
  logic                        run;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [7:0]                  cnt;
  logic                        ovf;
  logic signed [ACC_WIDTH-1:0] out_q;
  logic                        out_ovf_q;
  logic                        out_vld_q;

  logic signed [ACC_WIDTH:0]   sum_ext;
  logic signed [ACC_WIDTH-1:0] sum_sat;
  logic                        clamp;
  logic                        prod_rdy;
  logic                        accept;
  logic                        take;

  // run holds prod_rdy low through reset and the edge that releases it.
  assign prod_rdy = run & ((state == ST_ACC) | bus.acc_rdy);
  assign accept   = bus.prod_vld & prod_rdy;
  assign take     = out_vld_q & bus.acc_rdy;

  // One guard bit is enough: the two MSBs differ exactly when the step overflowed.
  always_comb begin
    sum_ext = {acc[ACC_WIDTH-1], acc} + {{EXT{bus.prod_in[DIN_WIDTH-1]}}, bus.prod_in};
    clamp   = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    if (!clamp)
      sum_sat = sum_ext[ACC_WIDTH-1:0];
    else if (sum_ext[ACC_WIDTH])
      sum_sat = SAT_MIN;
    else
      sum_sat = SAT_MAX;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_ACC;
      run       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_q     <= '0;
      out_ovf_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        if (cnt == LAST) begin
          // acc is already 0 in HOLD, so a product accepted alongside a take
          // naturally starts the next frame from zero.
          out_q     <= sum_sat;
          out_ovf_q <= ovf | clamp;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          state     <= ST_HOLD;
          out_vld_q <= 1'b1;
        end else begin
          acc <= sum_sat;
          cnt <= cnt + 8'd1;
          ovf <= ovf | clamp;
          if (take) begin
            state     <= ST_ACC;
            out_vld_q <= 1'b0;
          end
        end
      end else if (take) begin
        state     <= ST_ACC;
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.prod_rdy = prod_rdy;
  assign bus.acc_out  = out_q;
  assign bus.acc_ovf  = out_ovf_q;
  assign bus.acc_vld  = out_vld_q;

endmodule

// File: tb/tb_case_6_prod_accum.sv
// tb_case_6_prod_accum
// Directed bench for case_6_prod_accum. Three instances share clock/reset:
//   dut_a : ACC_WIDTH 16, LEN 8 (frames, backpressure, gaps, reset)
//   dut_b : ACC_WIDTH 12, LEN 8 (saturation)
//   dut_c : ACC_WIDTH 16, LEN 1 (every accept is final)
module tb_case_6_prod_accum;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 ap_clk = ~ap_clk;

  case_6_prod_accum_if #(.DIN_WIDTH(11), .ACC_WIDTH(16)) bus_a ();
  case_6_prod_accum_if #(.DIN_WIDTH(11), .ACC_WIDTH(12)) bus_b ();
  case_6_prod_accum_if #(.DIN_WIDTH(11), .ACC_WIDTH(16)) bus_c ();

  case_6_prod_accum #(.DIN_WIDTH(11), .ACC_WIDTH(16), .LEN(8)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_a));
  case_6_prod_accum #(.DIN_WIDTH(11), .ACC_WIDTH(12), .LEN(8)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_b));
  case_6_prod_accum #(.DIN_WIDTH(11), .ACC_WIDTH(16), .LEN(1)) dut_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_c));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push_a(input int v);
    bus_a.prod_in = 11'(v);
    bus_a.prod_vld = 1'b1;
    tick();
  endtask

  task automatic push_b(input int v);
    bus_b.prod_in = 11'(v);
    bus_b.prod_vld = 1'b1;
    tick();
  endtask

  task automatic push_c(input int v);
    bus_c.prod_in = 11'(v);
    bus_c.prod_vld = 1'b1;
    tick();
  endtask

  int frame_b [5][8] = '{
    '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023},
    '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024},
    '{1023, 1023, -1024, -1024, -1024, -1024, -1024, -1024},
    '{1023, 1023, 1, 0, 0, 0, 0, 0},
    '{1023, 1023, 1023, -1024, 0, 0, 0, 0}
  };
  int exp_out_b [5] = '{2047, -2048, -2048, 2047, 1023};
  int exp_ovf_b [5] = '{1, 1, 1, 0, 1};

  initial begin
    bus_a.prod_in = '0; bus_a.prod_vld = 1'b0; bus_a.acc_rdy = 1'b1;
    bus_b.prod_in = '0; bus_b.prod_vld = 1'b0; bus_b.acc_rdy = 1'b1;
    bus_c.prod_in = '0; bus_c.prod_vld = 1'b0; bus_c.acc_rdy = 1'b1;

    // reset values
    #12;
    chk("rst_prod_rdy", bus_a.prod_rdy, 0);
    chk("rst_acc_vld", bus_a.acc_vld, 0);
    chk("rst_acc_out", bus_a.acc_out, 0);
    chk("rst_acc_ovf", bus_a.acc_ovf, 0);
    #1 ap_rst_n = 1'b1;
    tick();
    chk("post_rst_prod_rdy_a", bus_a.prod_rdy, 1);
    chk("post_rst_prod_rdy_b", bus_b.prod_rdy, 1);

    // basic frame 1..8
    for (int i = 1; i <= 7; i++) push_a(i);
    chk("basic_vld_before_last", bus_a.acc_vld, 0);
    push_a(8);
    chk("basic_vld", bus_a.acc_vld, 1);
    chk("basic_out", bus_a.acc_out, 36);
    chk("basic_ovf", bus_a.acc_ovf, 0);
    chk("basic_no_bubble", bus_a.prod_rdy, 1);

    // signed mix, started with no bubble
    push_a(-1024);
    chk("basic_vld_one_cycle", bus_a.acc_vld, 0);
    push_a(1023); push_a(-5); push_a(3); push_a(0); push_a(0); push_a(0);
    push_a(0);
    chk("mix_vld", bus_a.acc_vld, 1);
    chk("mix_out", bus_a.acc_out, -3);
    chk("mix_ovf", bus_a.acc_ovf, 0);

    // backpressure with upstream holding 7
    bus_a.acc_rdy = 1'b0;
    bus_a.prod_in = 11'sd7;
    bus_a.prod_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_prod_rdy", bus_a.prod_rdy, 0);
      chk("bp_out_stable", bus_a.acc_out, -3);
      chk("bp_vld", bus_a.acc_vld, 1);
    end
    bus_a.acc_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", bus_a.prod_rdy, 1);
    @(posedge ap_clk); #1;
    chk("bp_taken_vld", bus_a.acc_vld, 0);
    chk("bp_taken_out", bus_a.acc_out, -3);
    for (int i = 0; i < 6; i++) push_a(1);
    chk("bp_frame_vld_early", bus_a.acc_vld, 0);
    push_a(1);
    chk("bp_frame_vld", bus_a.acc_vld, 1);
    chk("bp_frame_out", bus_a.acc_out, 14);

    // input gaps across 2,4,...,16
    for (int i = 1; i <= 8; i++) begin
      if ((i == 3) || ($urandom_range(0, 1) == 1)) begin
        bus_a.prod_vld = 1'b0;
        bus_a.prod_in = 11'sd99;
        tick();
      end
      push_a(2 * i);
    end
    chk("gaps_vld", bus_a.acc_vld, 1);
    chk("gaps_out", bus_a.acc_out, 72);
    chk("gaps_ovf", bus_a.acc_ovf, 0);
    bus_a.prod_vld = 1'b0;
    tick();
    chk("gaps_taken", bus_a.acc_vld, 0);

    // reset after 3 accepts
    push_a(1); push_a(1); push_a(1);
    bus_a.prod_vld = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("mrst_vld", bus_a.acc_vld, 0);
    chk("mrst_prod_rdy", bus_a.prod_rdy, 0);
    chk("mrst_out", bus_a.acc_out, 0);
    chk("mrst_ovf", bus_a.acc_ovf, 0);
    #1 ap_rst_n = 1'b1;
    tick();
    chk("mrst_prod_rdy_back", bus_a.prod_rdy, 1);
    for (int i = 0; i < 8; i++) push_a(1);
    chk("mrst_frame_vld", bus_a.acc_vld, 1);
    chk("mrst_frame_out", bus_a.acc_out, 8);

    // reset while a result is pending
    bus_a.acc_rdy = 1'b0;
    bus_a.prod_vld = 1'b0;
    tick();
    chk("hrst_pending", bus_a.acc_vld, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("hrst_vld", bus_a.acc_vld, 0);
    chk("hrst_out", bus_a.acc_out, 0);
    chk("hrst_prod_rdy", bus_a.prod_rdy, 0);
    #2 ap_rst_n = 1'b1;
    bus_a.acc_rdy = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push_a(2);
    chk("hrst_frame_out", bus_a.acc_out, 16);
    chk("hrst_frame_ovf", bus_a.acc_ovf, 0);
    bus_a.prod_vld = 1'b0;

    // saturation, 12-bit accumulator
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) push_b(frame_b[f][i]);
      chk("sat_vld", bus_b.acc_vld, 1);
      chk("sat_out", bus_b.acc_out, exp_out_b[f]);
      chk("sat_ovf", bus_b.acc_ovf, exp_ovf_b[f]);
    end
    bus_b.prod_vld = 1'b0;

    // LEN = 1
    push_c(5);
    chk("len1_out", bus_c.acc_out, 5);
    chk("len1_vld", bus_c.acc_vld, 1);
    push_c(-3);
    chk("len1_reload_out", bus_c.acc_out, -3);
    chk("len1_reload_vld", bus_c.acc_vld, 1);
    bus_c.acc_rdy = 1'b0;
    bus_c.prod_in = 11'sd9;
    tick();
    chk("len1_stall_out", bus_c.acc_out, -3);
    chk("len1_stall_rdy", bus_c.prod_rdy, 0);
    bus_c.acc_rdy = 1'b1;
    tick();
    chk("len1_resume_out", bus_c.acc_out, 9);
    chk("len1_resume_vld", bus_c.acc_vld, 1);
    bus_c.prod_vld = 1'b0;
    tick();
    chk("len1_taken", bus_c.acc_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
